// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types used by the input-port VC scheduler.
// Optional defines:
//   USE_QOS_VALUE  adds a qos_value field to the decoded head flit.
package rvh_noc_pkg;

   localparam int unsigned QoS_Value_Width = 4;
   localparam int unsigned NodeID_Width    = 4;

   // Output port index; wide enough to carry an out-of-range code for a 5-port router.
   typedef logic [2:0] io_port_t;

   typedef struct packed {
      io_port_t                   look_ahead_routing;
      logic [NodeID_Width-1:0]    tgt_id;
`ifdef USE_QOS_VALUE
      logic [QoS_Value_Width-1:0] qos_value;
`endif
   } flit_dec_t;

   typedef enum logic [0:0] {
      SCHED_IDLE = 1'b0,
      SCHED_REQ  = 1'b1
   } sched_state_e;

endpackage : rvh_noc_pkg

// File: rtl/input_port_vc_scheduler_chk.sv
// Simulation-only protocol checks for the input-port VC scheduler.
module input_port_vc_scheduler_chk #(
   parameter int unsigned VC_NUM       = 4,
   parameter int unsigned VC_NUM_IDX_W = $clog2(VC_NUM)
) (
   input logic                    clk,
   input logic                    rst,
   input logic                    sa_req_v,
   input logic [2:0]              sa_req_port,
   input logic [VC_NUM_IDX_W-1:0] sa_req_vc_id,
   input logic                    sa_gnt,
   input logic [VC_NUM-1:0]       vc_pop
);

   // A pop only accompanies a granted, live request; a stray grant is ignored.
   a_pop_needs_grant : assert property (@(posedge clk) disable iff (rst)
      (vc_pop != {VC_NUM{1'b0}}) |-> (sa_req_v && sa_gnt));

   // At most one VC is popped per cycle.
   a_pop_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(vc_pop));

   // An ungranted request stays up with the same port and VC.
   a_req_stable : assert property (@(posedge clk) disable iff (rst)
      (sa_req_v && !sa_gnt) |=> (sa_req_v && $stable(sa_req_port) && $stable(sa_req_vc_id)));

endmodule : input_port_vc_scheduler_chk

// File: rtl/vc_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr_i,
// wrapping modulo VC_NUM. Produces both a one-hot grant and its index.
module vc_rr_picker #(
   parameter int unsigned VC_NUM       = 4,
   parameter int unsigned VC_NUM_IDX_W = $clog2(VC_NUM)
) (
   input  logic [VC_NUM-1:0]       req_i,
   input  logic [VC_NUM_IDX_W-1:0] ptr_i,
   output logic [VC_NUM-1:0]       gnt_o,
   output logic [VC_NUM_IDX_W-1:0] idx_o,
   output logic                    found_o
);

   logic [VC_NUM_IDX_W:0]   sum_s;
   logic [VC_NUM_IDX_W-1:0] cand_s;
   logic                    hit_s;

   // Scan candidates in rotated order starting at the pointer; keep the first hit.
   always_comb begin
      idx_o   = {VC_NUM_IDX_W{1'b0}};
      found_o = 1'b0;
      sum_s   = {(VC_NUM_IDX_W+1){1'b0}};
      cand_s  = {VC_NUM_IDX_W{1'b0}};
      hit_s   = 1'b0;
      for (int k = 0; k < VC_NUM; k++) begin
         sum_s   = {1'b0, ptr_i} + (VC_NUM_IDX_W+1)'(k);
         cand_s  = (sum_s >= (VC_NUM_IDX_W+1)'(VC_NUM)) ?
                   VC_NUM_IDX_W'(sum_s - (VC_NUM_IDX_W+1)'(VC_NUM)) :
                   VC_NUM_IDX_W'(sum_s);
         hit_s   = ~found_o & req_i[cand_s];
         idx_o   = hit_s ? cand_s : idx_o;
         found_o = found_o | hit_s;
      end
   end

   // Expand the chosen index into a one-hot grant.
   always_comb begin
      if (found_o) begin
         gnt_o = {{(VC_NUM-1){1'b0}}, 1'b1} << idx_o;
      end else begin
         gnt_o = {VC_NUM{1'b0}};
      end
   end

endmodule : vc_rr_picker

// File: rtl/input_port_vc_scheduler.sv
// Input-port VC scheduler: chooses one VC whose head flit targets an output
// port with credit, requests the switch allocator, holds the request until
// granted, then pops that VC. Round-robin across VCs; a popped VC is masked
// for one cycle because its next head is not yet visible.
// Optional define:
//   INPUT_PORT_SCHED_QOS_EN  pick the highest qos_value first, round-robin on
//                            ties. Needs USE_QOS_VALUE so the field exists.
module input_port_vc_scheduler
   import rvh_noc_pkg::*;
#(
   parameter int unsigned VC_NUM          = 4,
   parameter int unsigned OUTPUT_PORT_NUM = 5,
   parameter int unsigned VC_NUM_IDX_W    = $clog2(VC_NUM)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [VC_NUM-1:0]          vc_head_v_i,
   input  flit_dec_t                  vc_head_dec_i [VC_NUM],
   input  logic [OUTPUT_PORT_NUM-1:0] out_credit_avail_i,
   output logic                       sa_req_v_o,
   output io_port_t                   sa_req_port_o,
   output logic [VC_NUM_IDX_W-1:0]    sa_req_vc_id_o,
   input  logic                       sa_gnt_i,
   output logic [VC_NUM-1:0]          vc_pop_o
);

   sched_state_e            state_r;
   logic                    req_v_r;
   io_port_t                req_port_r;
   logic [VC_NUM_IDX_W-1:0] sel_vc_r;
   logic [VC_NUM-1:0]       sel_oh_r;
   logic [VC_NUM_IDX_W-1:0] rr_ptr_r;
   logic [VC_NUM-1:0]       pop_mask_r;

   logic [VC_NUM-1:0]       eligible_s;
   logic [VC_NUM-1:0]       pick_req_s;
   logic [VC_NUM-1:0]       cand_req_s;
   logic [VC_NUM-1:0]       pick_gnt_s;
   logic [VC_NUM_IDX_W-1:0] pick_ptr_s;
   logic [VC_NUM_IDX_W-1:0] pick_idx_s;
   logic [VC_NUM_IDX_W-1:0] next_ptr_s;
   logic                    pick_found_s;
   logic                    granting_s;
   io_port_t                pick_port_s;
   logic                    unused_s;

   function automatic logic [VC_NUM_IDX_W-1:0] wrap_inc(input logic [VC_NUM_IDX_W-1:0] idx);
      if (32'(idx) == (VC_NUM - 32'd1)) begin
         return {VC_NUM_IDX_W{1'b0}};
      end else begin
         return idx + VC_NUM_IDX_W'(1);
      end
   endfunction

   // A VC is eligible when it has a head, targets an existing port with credit, and was not just popped.
   always_comb begin
      eligible_s = {VC_NUM{1'b0}};
      for (int i = 0; i < VC_NUM; i++) begin
         if (32'(vc_head_dec_i[i].look_ahead_routing) < OUTPUT_PORT_NUM) begin
            eligible_s[i] = vc_head_v_i[i]
                          & out_credit_avail_i[vc_head_dec_i[i].look_ahead_routing]
                          & ~pop_mask_r[i];
         end else begin
            eligible_s[i] = 1'b0;
         end
      end
   end

   assign granting_s = (state_r == SCHED_REQ) && sa_gnt_i;
   assign next_ptr_s = wrap_inc(sel_vc_r);

   // On a grant, reselect from just past the granted VC with that VC excluded; otherwise scan from rr_ptr.
   always_comb begin
      if (granting_s) begin
         pick_req_s = eligible_s & ~sel_oh_r;
         pick_ptr_s = next_ptr_s;
      end else begin
         pick_req_s = eligible_s;
         pick_ptr_s = rr_ptr_r;
      end
   end

`ifdef INPUT_PORT_SCHED_QOS_EN
   logic [QoS_Value_Width-1:0] max_qos_s;

   // Highest QoS value among the candidates.
   always_comb begin
      max_qos_s = {QoS_Value_Width{1'b0}};
      for (int i = 0; i < VC_NUM; i++) begin
         max_qos_s = (pick_req_s[i] && (vc_head_dec_i[i].qos_value > max_qos_s)) ?
                     vc_head_dec_i[i].qos_value : max_qos_s;
      end
   end

   // Keep only the candidates at that QoS level; round-robin breaks the tie.
   always_comb begin
      cand_req_s = {VC_NUM{1'b0}};
      for (int i = 0; i < VC_NUM; i++) begin
         cand_req_s[i] = pick_req_s[i] & (vc_head_dec_i[i].qos_value == max_qos_s);
      end
   end
`else
   assign cand_req_s = pick_req_s;
`endif

   vc_rr_picker #(
      .VC_NUM       (VC_NUM),
      .VC_NUM_IDX_W (VC_NUM_IDX_W)
   ) u_picker (
      .req_i   (cand_req_s),
      .ptr_i   (pick_ptr_s),
      .gnt_o   (pick_gnt_s),
      .idx_o   (pick_idx_s),
      .found_o (pick_found_s)
   );

   assign pick_port_s = vc_head_dec_i[pick_idx_s].look_ahead_routing;

   // Pop strobe follows the grant in the same cycle and is silent otherwise.
   always_comb begin
      if (granting_s) begin
         vc_pop_o = sel_oh_r;
      end else begin
         vc_pop_o = {VC_NUM{1'b0}};
      end
   end

   // Scheduler FSM: latch a selection, hold it until granted, then chain or go idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= SCHED_IDLE;
         req_v_r    <= 1'b0;
         req_port_r <= io_port_t'(0);
         sel_vc_r   <= {VC_NUM_IDX_W{1'b0}};
         sel_oh_r   <= {VC_NUM{1'b0}};
         rr_ptr_r   <= {VC_NUM_IDX_W{1'b0}};
         pop_mask_r <= {VC_NUM{1'b0}};
      end else begin
         pop_mask_r <= vc_pop_o;
         case (state_r)
            SCHED_IDLE: begin
               if (pick_found_s) begin
                  state_r    <= SCHED_REQ;
                  req_v_r    <= 1'b1;
                  req_port_r <= pick_port_s;
                  sel_vc_r   <= pick_idx_s;
                  sel_oh_r   <= pick_gnt_s;
               end else begin
                  state_r    <= SCHED_IDLE;
                  req_v_r    <= 1'b0;
               end
            end
            SCHED_REQ: begin
               if (sa_gnt_i) begin
                  rr_ptr_r <= next_ptr_s;
                  if (pick_found_s) begin
                     state_r    <= SCHED_REQ;
                     req_v_r    <= 1'b1;
                     req_port_r <= pick_port_s;
                     sel_vc_r   <= pick_idx_s;
                     sel_oh_r   <= pick_gnt_s;
                  end else begin
                     state_r    <= SCHED_IDLE;
                     req_v_r    <= 1'b0;
                  end
               end else begin
                  // Request held even if credit disappears; the SA does the final credit check.
                  state_r <= SCHED_REQ;
                  req_v_r <= 1'b1;
               end
            end
            default: begin
               state_r <= SCHED_IDLE;
               req_v_r <= 1'b0;
            end
         endcase
      end
   end

   assign sa_req_v_o     = req_v_r;
   assign sa_req_port_o  = req_port_r;
   assign sa_req_vc_id_o = sel_vc_r;

   // Fold decoder fields this scheduler does not look at (tgt_id and friends).
   always_comb begin
      unused_s = 1'b0;
      for (int i = 0; i < VC_NUM; i++) begin
         unused_s = unused_s ^ (^vc_head_dec_i[i]);
      end
   end

   input_port_vc_scheduler_chk #(
      .VC_NUM       (VC_NUM),
      .VC_NUM_IDX_W (VC_NUM_IDX_W)
   ) u_chk (
      .clk          (clk),
      .rst          (rst),
      .sa_req_v     (sa_req_v_o),
      .sa_req_port  (sa_req_port_o),
      .sa_req_vc_id (sa_req_vc_id_o),
      .sa_gnt       (sa_gnt_i),
      .vc_pop       (vc_pop_o)
   );

endmodule : input_port_vc_scheduler

// File: tb/tb_input_port_vc_scheduler.sv
// Scoreboard bench for input_port_vc_scheduler: expected grants are queued as
// stimulus is issued, a negedge monitor compares every granted request.
module tb_input_port_vc_scheduler;
   import rvh_noc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] head_v;
   flit_dec_t  dec [4];
   logic [4:0] credit;
   logic       gnt;
   logic       req_v;
   io_port_t   req_port;
   logic [1:0] req_vc;
   logic [3:0] pop;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q [$];
   logic [8:0] exp_e;

   input_port_vc_scheduler #(
      .VC_NUM          (4),
      .OUTPUT_PORT_NUM (5)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .vc_head_v_i        (head_v),
      .vc_head_dec_i      (dec),
      .out_credit_avail_i (credit),
      .sa_req_v_o         (req_v),
      .sa_req_port_o      (req_port),
      .sa_req_vc_id_o     (req_vc),
      .sa_gnt_i           (gnt),
      .vc_pop_o           (pop)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   // Monitor: every granted request must match the head of the expected queue; otherwise no pop.
   always @(negedge clk) begin
      if (!rst) begin
         if (req_v && gnt) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got vc=%0d port=%0d pop=%b, required no grant", req_vc, req_port, pop);
            end else begin
               exp_e = exp_q.pop_front();
               if ({req_vc, req_port, pop} !== exp_e) begin
                  errors++;
                  $display("FAIL sb_grant: got vc=%0d port=%0d pop=%b, required vc=%0d port=%0d pop=%b",
                           req_vc, req_port, pop, exp_e[8:7], exp_e[6:4], exp_e[3:0]);
               end
            end
         end else begin
            checks++;
            if (pop !== 4'b0000) begin
               errors++;
               $display("FAIL pop_without_grant: got pop=%b, required 0000", pop);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic expect_grant(input logic [1:0] vc, input logic [2:0] port, input logic [3:0] p);
      exp_q.push_back({vc, port, p});
   endtask

   task automatic clear_inputs();
      head_v = 4'b0000;
      credit = 5'b00000;
      gnt    = 1'b0;
      for (int i = 0; i < 4; i++) dec[i] = '0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();

      // Power-on reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_v", 32'(req_v), 32'd0);
      chk("rst_port", 32'(req_port), 32'd0);
      chk("rst_vc", 32'(req_vc), 32'd0);
      chk("rst_pop", 32'(pop), 32'd0);
      tick();
      rst = 1'b0;

      // Single VC: VC2 -> port 3, one-cycle request latency, then one-cycle mask after pop
      tick();
      head_v = 4'b0100;
      dec[2].look_ahead_routing = 3'd3;
      credit = 5'b01000;
      @(negedge clk);
      chk("single_latency", 32'(req_v), 32'd0);
      tick();
      @(negedge clk);
      chk("single_req_v", 32'(req_v), 32'd1);
      chk("single_vc", 32'(req_vc), 32'd2);
      chk("single_port", 32'(req_port), 32'd3);
      tick();
      gnt = 1'b1;
      expect_grant(2'd2, 3'd3, 4'b0100);
      tick();
      gnt = 1'b0;
      @(negedge clk);
      chk("single_after_pop", 32'(req_v), 32'd0);
      tick();
      @(negedge clk);
      chk("single_masked", 32'(req_v), 32'd0);
      tick();
      @(negedge clk);
      chk("single_rereq_v", 32'(req_v), 32'd1);
      chk("single_rereq_vc", 32'(req_vc), 32'd2);

      // Out-of-range ports are never requested; port 4 is the highest legal one
      do_reset();
      tick();
      head_v = 4'b0011;
      dec[0].look_ahead_routing = 3'd5;
      dec[1].look_ahead_routing = 3'd7;
      credit = 5'b11111;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("oor_no_req", 32'(req_v), 32'd0);
         tick();
      end
      head_v = 4'b0111;
      dec[2].look_ahead_routing = 3'd4;
      tick();
      @(negedge clk);
      chk("oor_port4_vc", 32'(req_vc), 32'd2);
      chk("oor_port4_port", 32'(req_port), 32'd4);
      tick();
      gnt = 1'b1;
      expect_grant(2'd2, 3'd4, 4'b0100);
      tick();
      gnt = 1'b0;
      head_v = 4'b0000;
      @(negedge clk);
      chk("oor_idle_after", 32'(req_v), 32'd0);

      // Credit gating and request hold while credit disappears
      do_reset();
      tick();
      head_v = 4'b0011;
      dec[0].look_ahead_routing = 3'd1;
      dec[1].look_ahead_routing = 3'd2;
      credit = 5'b00100;
      tick();
      @(negedge clk);
      chk("credit_req_v", 32'(req_v), 32'd1);
      chk("credit_vc", 32'(req_vc), 32'd1);
      chk("credit_port", 32'(req_port), 32'd2);
      tick();
      credit = 5'b00000;
      dec[1].look_ahead_routing = 3'd0;
      head_v = 4'b0111;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("hold_vc_port", 32'({req_v, req_vc, req_port}), 32'({1'b1, 2'd1, 3'd2}));
         tick();
      end
      gnt = 1'b1;
      expect_grant(2'd1, 3'd2, 4'b0010);
      tick();
      gnt = 1'b0;
      credit = 5'b11111;
      head_v = 4'b0100;
      dec[2].look_ahead_routing = 3'd2;
      @(negedge clk);
      chk("credit_idle_after", 32'(req_v), 32'd0);

      // Reset asserted mid-request with grant high: no pop, reset values, rr_ptr back to 0
      tick();
      @(negedge clk);
      chk("midrst_req_before", 32'({req_v, req_vc}), 32'({1'b1, 2'd2}));
      tick();
      rst = 1'b1;
      gnt = 1'b1;
      @(negedge clk);
      chk("midrst_req_v", 32'(req_v), 32'd0);
      chk("midrst_vc_port", 32'({req_vc, req_port}), 32'd0);
      chk("midrst_pop", 32'(pop), 32'd0);
      tick();
      rst = 1'b0;
      gnt = 1'b0;
      head_v = 4'b0000;

      // Fairness: all four eligible, grant tied high -> pops 0,1,2,3,0 back to back
      tick();
      for (int i = 0; i < 4; i++) dec[i].look_ahead_routing = 3'(i);
      head_v = 4'b1111;
      credit = 5'b11111;
      gnt = 1'b1;
      expect_grant(2'd0, 3'd0, 4'b0001);
      expect_grant(2'd1, 3'd1, 4'b0010);
      expect_grant(2'd2, 3'd2, 4'b0100);
      expect_grant(2'd3, 3'd3, 4'b1000);
      expect_grant(2'd0, 3'd0, 4'b0001);
      repeat (5) tick();
      tick();
      gnt = 1'b0;
      head_v = 4'b0000;
      @(negedge clk);
      chk("fair_all_pops", 32'(exp_q.size()), 32'd0);

`ifdef INPUT_PORT_SCHED_QOS_EN
      // QoS: higher value first, then round-robin among equal values
      do_reset();
      tick();
      dec[1].look_ahead_routing = 3'd1;
      dec[1].qos_value = 4'd2;
      dec[3].look_ahead_routing = 3'd3;
      dec[3].qos_value = 4'd5;
      head_v = 4'b1010;
      credit = 5'b11111;
      gnt = 1'b1;
      expect_grant(2'd3, 3'd3, 4'b1000);
      expect_grant(2'd1, 3'd1, 4'b0010);
      repeat (3) tick();
      gnt = 1'b0;
      head_v = 4'b0000;
      @(negedge clk);
      chk("qos_high_first", 32'(exp_q.size()), 32'd0);
      do_reset();
      tick();
      dec[0].look_ahead_routing = 3'd0;
      dec[0].qos_value = 4'd5;
      dec[3].look_ahead_routing = 3'd3;
      dec[3].qos_value = 4'd5;
      head_v = 4'b1001;
      credit = 5'b11111;
      gnt = 1'b1;
      expect_grant(2'd0, 3'd0, 4'b0001);
      expect_grant(2'd3, 3'd3, 4'b1000);
      repeat (3) tick();
      gnt = 1'b0;
      head_v = 4'b0000;
      @(negedge clk);
      chk("qos_tie_rr", 32'(exp_q.size()), 32'd0);
`endif

      tick();
      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_input_port_vc_scheduler
